// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter.
// Master 0 is the SPI bridge, master 1 a secondary on-chip requester.
// Grants alternate round-robin per bus cycle (CYC); a watchdog aborts
// a grant whose slave stops acknowledging.
module wb_arbiter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,

    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m0_we_i,
    input  logic                  m0_cycle_i,
    input  logic                  m0_strobe_i,
    output logic                  m0_stall_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    input  logic                  m1_we_i,
    input  logic                  m1_cycle_i,
    input  logic                  m1_strobe_i,
    output logic                  m1_stall_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_we_o,
    output logic                  s_cycle_o,
    output logic                  s_strobe_o,
    input  logic                  s_stall_i,
    input  logic                  s_ack_i,

    output logic                  busy_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t             state;
    logic               last_grant;
    logic [OUT_W-1:0]   outstanding;
    logic [TMR_W-1:0]   timer;

    logic               granted;
    logic               owner;
    logic               own_cycle;
    logic               own_strobe;
    logic               full;
    logic               accept;
    logic               ack_valid;
    logic               counting;

    assign granted    = (state == GRANT0) || (state == GRANT1);
    assign owner      = (state == GRANT1);
    assign own_cycle  = owner ? m1_cycle_i  : m0_cycle_i;
    assign own_strobe = owner ? m1_strobe_i : m0_strobe_i;
    assign full       = (outstanding == OUT_MAX);
    assign accept     = s_strobe_o && !s_stall_i;
    assign ack_valid  = granted && s_ack_i && (outstanding != '0);
    assign counting   = (outstanding != '0) && !s_ack_i;

    // Slave-side mux and per-master handshake returns, decoded from the registered state
    always_comb begin
        s_cycle_o  = granted;
        s_strobe_o = granted && own_strobe && !full;
        s_addr_o   = owner ? m1_addr_i : m0_addr_i;
        s_data_o   = owner ? m1_data_i : m0_data_i;
        s_we_o     = owner ? m1_we_i   : m0_we_i;
        busy_o     = (state != IDLE);

        m0_data_o  = s_data_i;
        m1_data_o  = s_data_i;

        m0_stall_o = m0_cycle_i;
        m1_stall_o = m1_cycle_i;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_err_o   = 1'b0;

        case (state)
            GRANT0: begin
                m0_stall_o = s_stall_i || full;
                m0_ack_o   = ack_valid;
            end
            GRANT1: begin
                m1_stall_o = s_stall_i || full;
                m1_ack_o   = ack_valid;
            end
            ABORT: begin
                if (last_grant) begin
                    m1_stall_o = 1'b1;
                    m1_err_o   = 1'b1;
                end else begin
                    m0_stall_o = 1'b1;
                    m0_err_o   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Arbitration FSM with outstanding-strobe accounting and the no-ack watchdog
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            outstanding <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    timer       <= '0;
                    if (m0_cycle_i && m1_cycle_i) begin
                        state <= last_grant ? GRANT0 : GRANT1;
                    end else if (m0_cycle_i) begin
                        state <= GRANT0;
                    end else if (m1_cycle_i) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (!own_cycle) begin
                        state       <= IDLE;
                        last_grant  <= owner;
                        outstanding <= '0;
                        timer       <= '0;
                    end else if (counting && (timer == TMR_LAST)) begin
                        state       <= ABORT;
                        last_grant  <= owner;
                        outstanding <= '0;
                        timer       <= '0;
                    end else begin
                        if (accept && !ack_valid && !full) begin
                            outstanding <= outstanding + OUT_W'(1);
                        end else if (!accept && ack_valid) begin
                            outstanding <= outstanding - OUT_W'(1);
                        end
                        timer <= counting ? (timer + TMR_W'(1)) : '0;
                    end
                end
                ABORT: begin
                    state       <= IDLE;
                    outstanding <= '0;
                    timer       <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
